// File: rtl/display_scan_if.sv
// Producer-side valid/ready channel carrying packed BCD digit values
// into the display scan controller.
interface display_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    in_valid;
    logic [4*NUM_DIGITS-1:0] in_data;
    logic                    in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Multiplexes NUM_DIGITS BCD digits onto one shared 7-segment decoder,
// committing new values only at frame boundaries.
module display_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int SLOT_CYCLES = 50000,
    parameter int DEAD_CYCLES = 16,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    display_scan_if.slave         io,
    output logic [3:0]            digit_data,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  frame_done,
    output logic                  active
);
    localparam int SW = $clog2(SLOT_CYCLES);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;

    typedef enum logic {
        IDLE,
        SCAN
    } state_e;

    state_e                state_q, state_d;
    logic [SW-1:0]         slot_cnt_q, slot_cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         shown_q, shown_d;
    logic [DW-1:0]         pend_q, pend_d;
    logic                  pend_full_q, pend_full_d;
    logic [3:0]            data_q, data_d;
    logic [NUM_DIGITS-1:0] en_q, en_d;

    logic                  accept;
    logic                  last_slot;
    logic                  last_idx;
    logic                  boundary;
    logic [3:0]            cur_code;
    logic [NUM_DIGITS-1:0] lz;
    logic                  blank;

    assign io.in_ready = !pend_full_q;
    assign accept      = io.in_valid && !pend_full_q;
    assign last_slot   = slot_cnt_q == SW'(SLOT_CYCLES - 1);
    assign last_idx    = idx_q == IW'(NUM_DIGITS - 1);
    assign boundary    = (state_q == SCAN) && last_slot && last_idx;
    assign cur_code    = shown_q[{idx_q, 2'b00} +: 4];

    // lz[i]: digits i..NUM_DIGITS-1 of the shown value are all zero
    always_comb begin
        logic run;
        run = 1'b1;
        lz  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run   = run && (shown_q[4*i +: 4] == 4'd0);
            lz[i] = run;
        end
    end

    assign blank = (cur_code > 4'd9) ||
                   (BLANK_LZ && (idx_q != '0) && lz[idx_q]);

    always_comb begin
        state_d     = state_q;
        slot_cnt_d  = slot_cnt_q;
        idx_d       = idx_q;
        shown_d     = shown_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        data_d      = '0;
        en_d        = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SCAN;
                    shown_d = io.in_data;
                end
            end
            SCAN: begin
                if (last_slot) begin
                    slot_cnt_d = '0;
                    idx_d      = last_idx ? '0 : idx_q + 1'b1;
                end else begin
                    slot_cnt_d = slot_cnt_q + 1'b1;
                end
                if (boundary && pend_full_q) begin
                    shown_d     = pend_q;
                    pend_full_d = 1'b0;
                end
                // accept implies pending empty, so it never collides with a commit
                if (accept) begin
                    pend_d      = io.in_data;
                    pend_full_d = 1'b1;
                end
                data_d = cur_code;
                if ((slot_cnt_q >= SW'(DEAD_CYCLES)) && !blank) begin
                    en_d = NUM_DIGITS'(1) << idx_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            slot_cnt_q  <= '0;
            idx_q       <= '0;
            shown_q     <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            data_q      <= '0;
            en_q        <= '0;
        end else begin
            state_q     <= state_d;
            slot_cnt_q  <= slot_cnt_d;
            idx_q       <= idx_d;
            shown_q     <= shown_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            data_q      <= data_d;
            en_q        <= en_d;
        end
    end

    assign digit_data = data_q;
    assign digit_en   = en_q;
    assign frame_done = boundary;
    assign active     = state_q == SCAN;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: scan order, blanking,
// frame-aligned commits, handshake back-pressure and async reset.
module tb_display_scan_ctrl;
    logic       clk;
    logic       rst_n;
    logic [3:0] digit_data;
    logic [3:0] digit_en;
    logic       frame_done;
    logic       active;
    logic       p;

    int errors = 0;
    int checks = 0;

    display_scan_if #(.NUM_DIGITS(4)) bus ();

    display_scan_ctrl #(
        .NUM_DIGITS (4),
        .SLOT_CYCLES(8),
        .DEAD_CYCLES(2),
        .BLANK_LZ   (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .io        (bus.slave),
        .digit_data(digit_data),
        .digit_en  (digit_en),
        .frame_done(frame_done),
        .active    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Leaves the bench on the negedge right after the accepting edge.
    task automatic load(input logic [15:0] v);
        @(negedge clk);
        chk("idle_active", active, 0);
        chk("idle_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("ld_active", active, 1);
        chk("ld_ready", bus.in_ready, 1);
    endtask

    // One 32-cycle frame. dig/vis are the hand-derived digits and
    // visible slots; la/lb are cycles at which a one-cycle offer is made.
    task automatic run_frame(input logic [15:0] dig,
                             input logic [3:0]  vis,
                             input int          la,
                             input logic [15:0] lv,
                             input int          lb,
                             input logic [15:0] lbv,
                             input logic        p_in,
                             output logic       p_out);
        logic       pend;
        logic       vld;
        logic [3:0] en_exp;
        int         s;
        int         d;
        pend = p_in;
        vld  = 1'b0;
        for (int n = 1; n <= 32; n++) begin
            @(posedge clk);
            pend = (vld && !pend) || (pend && (n != 32));
            @(negedge clk);
            bus.in_valid = 1'b0;
            s = (n - 1) % 8;
            d = (n - 1) / 8;
            en_exp = (s >= 2 && vis[d]) ? 4'(1 << d) : 4'b0000;
            chk("data", digit_data, dig[4*d +: 4]);
            chk("en", digit_en, en_exp);
            chk("fdone", frame_done, n == 31);
            chk("ready", bus.in_ready, !pend);
            if (n == la) begin
                bus.in_valid = 1'b1;
                bus.in_data  = lv;
            end
            if (n == lb) begin
                bus.in_valid = 1'b1;
                bus.in_data  = lbv;
            end
            vld = bus.in_valid;
        end
        p_out = pend;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_en", digit_en, 0);
        chk("rst_data", digit_data, 0);
        chk("rst_fdone", frame_done, 0);
        chk("rst_active", active, 0);
        chk("rst_ready", bus.in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        load(16'h1234);
        run_frame(16'h1234, 4'b1111, -1, 16'h0, -1, 16'h0, 1'b0, p);
        run_frame(16'h1234, 4'b1111, 10, 16'h5678, 20, 16'h9999, p, p);
        run_frame(16'h5678, 4'b1111, 31, 16'h4321, -1, 16'h0, p, p);
        run_frame(16'h5678, 4'b1111, -1, 16'h0, -1, 16'h0, p, p);
        run_frame(16'h4321, 4'b1111, -1, 16'h0, -1, 16'h0, p, p);

        repeat (4) @(posedge clk);
        #2;
        chk("pre_rst_en", digit_en, 4'b0001);
        chk("pre_rst_data", digit_data, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", digit_en, 0);
        chk("mid_rst_data", digit_data, 0);
        chk("mid_rst_active", active, 0);
        chk("mid_rst_ready", bus.in_ready, 1);
        chk("mid_rst_fdone", frame_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_hold_active", active, 0);
            chk("idle_hold_en", digit_en, 0);
        end

        load(16'h0007);
        run_frame(16'h0007, 4'b0001, -1, 16'h0, -1, 16'h0, 1'b0, p);

        do_reset();
        load(16'h0000);
        run_frame(16'h0000, 4'b0001, -1, 16'h0, -1, 16'h0, 1'b0, p);

        do_reset();
        load(16'h12A4);
        run_frame(16'h12A4, 4'b1101, -1, 16'h0, -1, 16'h0, 1'b0, p);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
